// File: rtl/timer0_sfr_ctrl_pkg.sv
// Shared constants and types for the timer0 SFR front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: SFR address map, staged-write FSM encoding, 24-bit count type,
// and the wrap-detect helper used by the count-update path.
package timer0_sfr_pkg;

    localparam int CNT_W = 24;

    // Architectural count registers
    localparam logic [7:0] SFR_TL0 = 8'h8A;
    localparam logic [7:0] SFR_TM0 = 8'h8E;
    localparam logic [7:0] SFR_TH0 = 8'h8C;

    // Reload registers, only decoded when auto-reload is built in
    localparam logic [7:0] SFR_RL0 = 8'h9A;
    localparam logic [7:0] SFR_RM0 = 8'h9E;
    localparam logic [7:0] SFR_RH0 = 8'h9C;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STAGED = 1'b1
    } wr_state_t;

    // Counting up through all-ones to zero, or down through zero to all-ones.
    function automatic logic is_wrap(input cnt_t cur, input cnt_t nxt);
        return ((cur == {CNT_W{1'b1}}) && (nxt == '0)) ||
               ((cur == '0) && (nxt == {CNT_W{1'b1}}));
    endfunction

endpackage

// File: rtl/timer0_sfr_ctrl_if.sv
// Bundles the CPU SFR bus, the timer0 count exchange and the status outputs.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle and always accepted.
// Ports: sfr_wr_i/sfr_rd_i/sfr_addr_i/sfr_wdata_i (CPU in), sfr_rdata_o/
// sfr_rvalid_o (CPU out), tf0_clr_i, t0_*_o (count to timer0), t0_*_i (next
// count from timer0), tf0_o, tick_o, stage_err_o.
interface timer0_sfr_ctrl_if;

    logic       sfr_wr_i;
    logic       sfr_rd_i;
    logic [7:0] sfr_addr_i;
    logic [7:0] sfr_wdata_i;
    logic [7:0] sfr_rdata_o;
    logic       sfr_rvalid_o;
    logic       tf0_clr_i;
    logic [7:0] t0_th0_o;
    logic [7:0] t0_tm0_o;
    logic [7:0] t0_tl0_o;
    logic [7:0] t0_th0_i;
    logic [7:0] t0_tm0_i;
    logic [7:0] t0_tl0_i;
    logic       tf0_o;
    logic       tick_o;
    logic       stage_err_o;

    // Environment side: CPU plus timer0 datapath
    modport master (
        output sfr_wr_i, sfr_rd_i, sfr_addr_i, sfr_wdata_i, tf0_clr_i,
        output t0_th0_i, t0_tm0_i, t0_tl0_i,
        input  sfr_rdata_o, sfr_rvalid_o, t0_th0_o, t0_tm0_o, t0_tl0_o,
        input  tf0_o, tick_o, stage_err_o
    );

    // Controller side
    modport slave (
        input  sfr_wr_i, sfr_rd_i, sfr_addr_i, sfr_wdata_i, tf0_clr_i,
        input  t0_th0_i, t0_tm0_i, t0_tl0_i,
        output sfr_rdata_o, sfr_rvalid_o, t0_th0_o, t0_tm0_o, t0_tl0_o,
        output tf0_o, tick_o, stage_err_o
    );

endinterface

// File: rtl/timer0_sfr_ctrl_prescaler.sv
// Machine-cycle tick generator: counts 0..PRESCALE-1 and flags the last value.
// Latency: o_tick is combinational from the counter; high one cycle in PRESCALE.
// Backpressure: none; free-running.
// Ports: i_clk, i_rst (sync, active-high), o_tick.
module timer0_prescaler #(
    parameter int PRESCALE = 12
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    logic [7:0] r_cnt;
    logic       w_last;

    assign w_last = (r_cnt == 8'(PRESCALE - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tick = w_last;

endmodule

// File: rtl/timer0_sfr_ctrl.sv
// Timer0 sequencer/SFR front-end: owns TH0/TM0/TL0 and TF0, gates timer0's
// next-count onto prescaler ticks, and gives the CPU atomic 24-bit access.
// Latency: count updates one cycle after tick; read data one cycle after rd.
// Backpressure: none; SFR strobes always accepted, commit beats the tick.
// Ports: timers_clock_i, timers_reset_i (sync, active-high), sfr_if (slave).
// Optional: TIMER0_AUTO_RELOAD_EN adds RL0/RM0/RH0 loaded into the count on wrap.
module timer0_sfr_ctrl
    import timer0_sfr_pkg::*;
#(
    parameter int         PRESCALE      = 12,
    parameter int         STAGE_TIMEOUT = 16,
    parameter logic [7:0] ADDR_TL0      = SFR_TL0,
    parameter logic [7:0] ADDR_TM0      = SFR_TM0,
    parameter logic [7:0] ADDR_TH0      = SFR_TH0
`ifdef TIMER0_AUTO_RELOAD_EN
    ,
    parameter logic [7:0] ADDR_RL0      = SFR_RL0,
    parameter logic [7:0] ADDR_RM0      = SFR_RM0,
    parameter logic [7:0] ADDR_RH0      = SFR_RH0
`endif
) (
    input  logic              timers_clock_i,
    input  logic              timers_reset_i,
    timer0_sfr_ctrl_if.slave  sfr_if
);

    localparam int TW = $clog2(STAGE_TIMEOUT + 1);

    // ---------------- state ----------------
    cnt_t       r_cnt;
    logic       r_tf0;
    wr_state_t  r_state;
    logic [7:0] r_stg_h;
    logic [7:0] r_stg_m;
    logic [TW-1:0] r_tmo;
    logic       r_stage_err;
    logic [7:0] r_rdata;
    logic       r_rvalid;
    logic [7:0] r_snap_h;
    logic [7:0] r_snap_m;
`ifdef TIMER0_AUTO_RELOAD_EN
    logic [7:0] r_rl;
    logic [7:0] r_rm;
    logic [7:0] r_rh;
`endif

    // ---------------- combinational ----------------
    logic w_tick;
    cnt_t w_next;
    logic w_wr_tl;
    logic w_wr_tm;
    logic w_wr_th;
    cnt_t w_commit_val;
    logic w_wrap;

    timer0_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk  (timers_clock_i),
        .i_rst  (timers_reset_i),
        .o_tick (w_tick)
    );

    assign w_next  = {sfr_if.t0_th0_i, sfr_if.t0_tm0_i, sfr_if.t0_tl0_i};
    assign w_wr_tl = sfr_if.sfr_wr_i && (sfr_if.sfr_addr_i == ADDR_TL0);
    assign w_wr_tm = sfr_if.sfr_wr_i && (sfr_if.sfr_addr_i == ADDR_TM0);
    assign w_wr_th = sfr_if.sfr_wr_i && (sfr_if.sfr_addr_i == ADDR_TH0);

    // A TL0 write always commits; the upper bytes come from the stage only
    // when a TH0/TM0 write is pending, otherwise from the live count.
    assign w_commit_val = (r_state == ST_STAGED)
                        ? {r_stg_h, r_stg_m, sfr_if.sfr_wdata_i}
                        : {r_cnt[23:8], sfr_if.sfr_wdata_i};

    // A commit swallows the tick entirely, so no wrap can be reported for it.
    assign w_wrap = w_tick && !w_wr_tl && is_wrap(r_cnt, w_next);

    // ---------------- count and TF0 ----------------
    always_ff @(posedge timers_clock_i) begin
        if (timers_reset_i) begin
            r_cnt <= '0;
            r_tf0 <= 1'b0;
        end else begin
            if (w_wr_tl) begin
                r_cnt <= w_commit_val;
            end else if (w_tick) begin
`ifdef TIMER0_AUTO_RELOAD_EN
                r_cnt <= w_wrap ? {r_rh, r_rm, r_rl} : w_next;
`else
                r_cnt <= w_next;
`endif
            end

            // Set has priority so an overflow racing an acknowledge is not lost.
            if (w_wrap) begin
                r_tf0 <= 1'b1;
            end else if (sfr_if.tf0_clr_i) begin
                r_tf0 <= 1'b0;
            end
        end
    end

    // ---------------- staged-write FSM ----------------
    always_ff @(posedge timers_clock_i) begin
        if (timers_reset_i) begin
            r_state     <= ST_IDLE;
            r_stg_h     <= '0;
            r_stg_m     <= '0;
            r_tmo       <= '0;
            r_stage_err <= 1'b0;
        end else begin
            r_stage_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_th) begin
                        r_stg_h <= sfr_if.sfr_wdata_i;
                        r_stg_m <= r_cnt[15:8];
                        r_tmo   <= '0;
                        r_state <= ST_STAGED;
                    end else if (w_wr_tm) begin
                        r_stg_h <= r_cnt[23:16];
                        r_stg_m <= sfr_if.sfr_wdata_i;
                        r_tmo   <= '0;
                        r_state <= ST_STAGED;
                    end
                end
                ST_STAGED: begin
                    // CPU activity on the expiry cycle still wins over discard.
                    if (w_wr_tl) begin
                        r_state <= ST_IDLE;
                    end else if (w_wr_th) begin
                        r_stg_h <= sfr_if.sfr_wdata_i;
                        r_tmo   <= '0;
                    end else if (w_wr_tm) begin
                        r_stg_m <= sfr_if.sfr_wdata_i;
                        r_tmo   <= '0;
                    end else if (r_tmo == TW'(STAGE_TIMEOUT - 1)) begin
                        r_stage_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef TIMER0_AUTO_RELOAD_EN
    // ---------------- reload registers (direct, unstaged) ----------------
    always_ff @(posedge timers_clock_i) begin
        if (timers_reset_i) begin
            r_rl <= '0;
            r_rm <= '0;
            r_rh <= '0;
        end else if (sfr_if.sfr_wr_i) begin
            if (sfr_if.sfr_addr_i == ADDR_RL0) r_rl <= sfr_if.sfr_wdata_i;
            if (sfr_if.sfr_addr_i == ADDR_RM0) r_rm <= sfr_if.sfr_wdata_i;
            if (sfr_if.sfr_addr_i == ADDR_RH0) r_rh <= sfr_if.sfr_wdata_i;
        end
    end
`endif

    // ---------------- read path ----------------
    // Reading TL0 freezes TM0/TH0 so a TL0,TM0,TH0 sequence sees one value.
    // All sources are pre-update registers, so a same-cycle write is not seen.
    always_ff @(posedge timers_clock_i) begin
        if (timers_reset_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_snap_h <= '0;
            r_snap_m <= '0;
        end else begin
            r_rvalid <= sfr_if.sfr_rd_i;
            if (sfr_if.sfr_rd_i) begin
                case (sfr_if.sfr_addr_i)
                    ADDR_TL0: begin
                        r_rdata  <= r_cnt[7:0];
                        r_snap_m <= r_cnt[15:8];
                        r_snap_h <= r_cnt[23:16];
                    end
                    ADDR_TM0: r_rdata <= r_snap_m;
                    ADDR_TH0: r_rdata <= r_snap_h;
`ifdef TIMER0_AUTO_RELOAD_EN
                    ADDR_RL0: r_rdata <= r_rl;
                    ADDR_RM0: r_rdata <= r_rm;
                    ADDR_RH0: r_rdata <= r_rh;
`endif
                    default:  r_rdata <= 8'h00;
                endcase
            end
        end
    end

    // ---------------- outputs ----------------
    assign sfr_if.t0_th0_o     = r_cnt[23:16];
    assign sfr_if.t0_tm0_o     = r_cnt[15:8];
    assign sfr_if.t0_tl0_o     = r_cnt[7:0];
    assign sfr_if.tf0_o        = r_tf0;
    assign sfr_if.tick_o       = w_tick;
    assign sfr_if.stage_err_o  = r_stage_err;
    assign sfr_if.sfr_rdata_o  = r_rdata;
    assign sfr_if.sfr_rvalid_o = r_rvalid;

endmodule

// File: tb/tb_timer0_sfr_ctrl.sv
// Directed bench for timer0_sfr_ctrl with a behavioural timer0 (+1 / -1).
// Latency: n/a.
// Backpressure: n/a.
module tb_timer0_sfr_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic up;
    int   k;
    int   total;
    int   bad;
    int   errseen;

    always #5 clk = ~clk;

    timer0_sfr_ctrl_if bus ();

    timer0_sfr_ctrl dut (
        .timers_clock_i (clk),
        .timers_reset_i (rst),
        .sfr_if         (bus)
    );

    // timer0 datapath model
    logic [23:0] cur;
    assign cur = {bus.t0_th0_o, bus.t0_tm0_o, bus.t0_tl0_o};
    assign {bus.t0_th0_i, bus.t0_tm0_i, bus.t0_tl0_i} = up ? (cur + 24'd1) : (cur - 24'd1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // k counts falling edges since reset release; one rising edge lies between.
    task automatic cyc();
        @(negedge clk);
        k++;
    endtask

    task automatic until_k(input int kt);
        while (k < kt) cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.sfr_addr_i  = a;
        bus.sfr_wdata_i = d;
        bus.sfr_wr_i    = 1'b1;
        cyc();
        bus.sfr_wr_i    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        bus.sfr_addr_i = a;
        bus.sfr_rd_i   = 1'b1;
        cyc();
        bus.sfr_rd_i   = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; k = 0; errseen = 0;
        up = 1'b1; rst = 1'b1;
        bus.sfr_wr_i = 1'b0; bus.sfr_rd_i = 1'b0;
        bus.sfr_addr_i = 8'h00; bus.sfr_wdata_i = 8'h00; bus.tf0_clr_i = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cnt",    cur, 24'h0);
        chk("rst_tf0",    bus.tf0_o, 1'b0);
        chk("rst_tick",   bus.tick_o, 1'b0);
        chk("rst_rdata",  bus.sfr_rdata_o, 8'h00);
        chk("rst_rvalid", bus.sfr_rvalid_o, 1'b0);
        chk("rst_err",    bus.stage_err_o, 1'b0);

        rst = 1'b0; k = 0;

        // prescaler and plain counting
        until_k(10); chk("tick_pre",  bus.tick_o, 1'b0);
        until_k(11); chk("tick_11",   bus.tick_o, 1'b1);
                     chk("cnt_11",    cur, 24'h0);
        until_k(12); chk("tick_12",   bus.tick_o, 1'b0);
                     chk("cnt_12",    cur, 24'h1);
        until_k(23); chk("tick_23",   bus.tick_o, 1'b1);
        until_k(24); chk("cnt_24",    cur, 24'h2);

        // atomic staged write
        wr(8'h8C, 8'h12); chk("stg_th", cur, 24'h2);
        wr(8'h8E, 8'h34); chk("stg_tm", cur, 24'h2);
        wr(8'h8A, 8'h56); chk("commit", cur, 24'h123456);
        until_k(36);      chk("cnt_36", cur, 24'h123457);

        // staging timeout
        wr(8'h8C, 8'hAA);
        until_k(52); chk("err_52", bus.stage_err_o, 1'b0);
        cyc();       chk("err_53", bus.stage_err_o, 1'b1);
        cyc();       chk("err_54", bus.stage_err_o, 1'b0);
                     chk("cnt_after_discard", cur, 24'h123458);
        wr(8'h8A, 8'h77); chk("tl_live", cur, 24'h123477);

        // up-wrap and TF0
        wr(8'h8C, 8'hFF); wr(8'h8E, 8'hFF); wr(8'h8A, 8'hFF);
        chk("cnt_ff", cur, 24'hFFFFFF);
        until_k(59); chk("tick_59", bus.tick_o, 1'b1);
                     chk("tf0_pre", bus.tf0_o, 1'b0);
        until_k(60); chk("wrap_cnt", cur, 24'h0);
                     chk("wrap_tf0", bus.tf0_o, 1'b1);
        bus.tf0_clr_i = 1'b1; cyc(); bus.tf0_clr_i = 1'b0;
        chk("tf0_clr", bus.tf0_o, 1'b0);
        wr(8'h8C, 8'hFF); wr(8'h8E, 8'hFF); wr(8'h8A, 8'hFF);
        until_k(71);
        bus.tf0_clr_i = 1'b1; cyc(); bus.tf0_clr_i = 1'b0;
        chk("set_wins_tf0", bus.tf0_o, 1'b1);
        chk("set_wins_cnt", cur, 24'h0);

        // commit in a tick cycle beats the increment
        until_k(83); chk("tick_83", bus.tick_o, 1'b1);
        wr(8'h8A, 8'h10); chk("commit_vs_tick", cur, 24'h000010);

        // read snapshot
        wr(8'h8C, 8'h01); wr(8'h8E, 8'h00); wr(8'h8A, 8'hFF);
        chk("cnt_0100ff", cur, 24'h0100FF);
        rd(8'h8A); chk("rd_tl_v", bus.sfr_rvalid_o, 1'b1);
                   chk("rd_tl_d", bus.sfr_rdata_o, 8'hFF);
        cyc();     chk("rd_v_drop", bus.sfr_rvalid_o, 1'b0);
        until_k(96); chk("cnt_010100", cur, 24'h010100);
        rd(8'h8C); chk("rd_th_v", bus.sfr_rvalid_o, 1'b1);
                   chk("rd_th_d", bus.sfr_rdata_o, 8'h01);
        rd(8'h55); chk("rd_unm_v", bus.sfr_rvalid_o, 1'b1);
                   chk("rd_unm_d", bus.sfr_rdata_o, 8'h00);
        rd(8'h8E); chk("rd_tm_v", bus.sfr_rvalid_o, 1'b1);
                   chk("rd_tm_d", bus.sfr_rdata_o, 8'h00);

        // simultaneous read and write of TL0
        bus.sfr_wr_i = 1'b1; bus.sfr_addr_i = 8'h8A; bus.sfr_wdata_i = 8'h33;
        rd(8'h8A);
        chk("rw1_d", bus.sfr_rdata_o, 8'h00);
        chk("rw1_c", cur, 24'h010133);
        bus.sfr_wdata_i = 8'h44;
        rd(8'h8A);
        bus.sfr_wr_i = 1'b0;
        chk("rw2_d", bus.sfr_rdata_o, 8'h33);
        chk("rw2_c", cur, 24'h010144);

        // reset in the middle of staging
        wr(8'h8C, 8'h5A);
        rst = 1'b1; cyc(); cyc();
        chk("mrst_cnt",   cur, 24'h0);
        chk("mrst_tf0",   bus.tf0_o, 1'b0);
        chk("mrst_err",   bus.stage_err_o, 1'b0);
        chk("mrst_rdata", bus.sfr_rdata_o, 8'h00);
        rst = 1'b0; k = 0; up = 1'b0;
        while (k < 11) begin
            cyc();
            if (bus.stage_err_o !== 1'b0) errseen++;
        end
        cyc();
`ifdef TIMER0_AUTO_RELOAD_EN
        chk("dn_wrap_cnt", cur, 24'h000000);
`else
        chk("dn_wrap_cnt", cur, 24'hFFFFFF);
`endif
        chk("dn_wrap_tf0", bus.tf0_o, 1'b1);
        while (k < 24) begin
            cyc();
            if (bus.stage_err_o !== 1'b0) errseen++;
        end
        chk("mrst_no_err", errseen, 0);

`ifdef TIMER0_AUTO_RELOAD_EN
        up = 1'b1;
        wr(8'h9C, 8'hFF); wr(8'h9E, 8'hFF); wr(8'h9A, 8'hF0);
        wr(8'h8C, 8'hFF); wr(8'h8E, 8'hFF); wr(8'h8A, 8'hFF);
        rd(8'h9A); chk("rd_rl", bus.sfr_rdata_o, 8'hF0);
        bus.tf0_clr_i = 1'b1; cyc(); bus.tf0_clr_i = 1'b0;
        chk("rl_tf0_pre", bus.tf0_o, 1'b0);
        until_k(36);
        chk("reload_cnt", cur, 24'hFFFFF0);
        chk("reload_tf0", bus.tf0_o, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
